// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressable data memory for the MIPS datapath.
// Supports byte/half/word loads and stores with sign or zero extension and a
// configurable read latency behind a REQ/READY/VALID handshake. Misaligned,
// out-of-range and illegal-size accesses complete with FAULT instead of
// touching memory. Optionally sweeps the whole array to zero after reset.
module data_memory_ctrl #(
  parameter int DEPTH          = 64,   // 32-bit words, power of 2, >= 4
  parameter int READ_LAT       = 1,    // 1..4
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        REQ,
  input  logic        WE,
  input  logic [1:0]  SIZE,
  input  logic        UNS,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic        READY,
  output logic        VALID,
  output logic [31:0] RD,
  output logic        FAULT,
  output logic [31:0] FAULT_ADDR,
  output logic        FAULT_STICKY
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [2:0]    LAT      = 3'(READ_LAT);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_READ  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] clr_idx;   // next word to zero during the clear sweep
  logic [2:0]    cnt;       // remaining READ cycles, 1 = last one
  logic [31:0]   hold;      // extended load result waiting for its VALID slot

  // Request decode
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic          bad;
  logic          accept;
  logic          do_store;
  logic [31:0]   word;
  logic [7:0]    bsel;
  logic [15:0]   hsel;
  logic [31:0]   ext;
  logic [31:0]   wmask;
  logic [31:0]   wdata;

  assign widx = A[AW+1:2];
  assign lane = A[1:0];

  // Fault check: illegal size, misalignment, or address beyond the array
  always_comb begin
    bad = 1'b0;
    case (SIZE)
      2'b01:   bad = A[0];
      2'b10:   bad = |A[1:0];
      2'b11:   bad = 1'b1;
      default: bad = 1'b0;
    endcase
    if (|(A >> (AW + 2))) bad = 1'b1;
  end

  // Load path: pick the addressed byte or half and extend it
  always_comb begin
    word = mem[widx];
    bsel = 8'(word >> {lane, 3'b000});
    hsel = A[1] ? word[31:16] : word[15:0];
    case (SIZE)
      2'b00:   ext = UNS ? {24'h0, bsel} : {{24{bsel[7]}}, bsel};
      2'b01:   ext = UNS ? {16'h0, hsel} : {{16{hsel[15]}}, hsel};
      default: ext = word;
    endcase
  end

  // Store path: replicate the right-aligned data across lanes, mask the target
  always_comb begin
    case (SIZE)
      2'b00: begin
        wmask = 32'h0000_00FF << {lane, 3'b000};
        wdata = {4{WD[7:0]}};
      end
      2'b01: begin
        wmask = A[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wdata = {2{WD[15:0]}};
      end
      default: begin
        wmask = 32'hFFFF_FFFF;
        wdata = WD;
      end
    endcase
  end

  // Next-state logic; only IDLE accepts, and only good loads leave IDLE
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_CLEAR: if (clr_idx == LAST_IDX) state_nxt = S_IDLE;
      S_IDLE: begin
        if (REQ) begin
          accept = 1'b1;
          if (!bad && !WE) state_nxt = S_READ;
        end
      end
      S_READ:  if (cnt == 3'd1) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign do_store = accept & WE & ~bad;

  // State register and registered outputs; VALID is a one-cycle pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      READY        <= !CLEAR_ON_RESET;
      clr_idx      <= '0;
      cnt          <= '0;
      hold         <= '0;
      VALID        <= 1'b0;
      FAULT        <= 1'b0;
      RD           <= '0;
      FAULT_ADDR   <= '0;
      FAULT_STICKY <= 1'b0;
    end else begin
      state <= state_nxt;
      READY <= (state_nxt == S_IDLE);
      VALID <= 1'b0;
      FAULT <= 1'b0;
      RD    <= '0;
      if (state == S_CLEAR) clr_idx <= clr_idx + 1'b1;
      if (accept) begin
        if (bad) begin
          VALID        <= 1'b1;
          FAULT        <= 1'b1;
          FAULT_ADDR   <= A;
          FAULT_STICKY <= 1'b1;
        end else if (WE) begin
          VALID <= 1'b1;
        end else begin
          // The word is sampled now, so a store right before is always seen
          cnt  <= LAT;
          hold <= ext;
          if (LAT == 3'd1) begin
            VALID <= 1'b1;
            RD    <= ext;
          end
        end
      end
      if (state == S_READ) begin
        cnt <= cnt - 3'd1;
        // Entering the last READ cycle: present the result
        if (cnt == 3'd2) begin
          VALID <= 1'b1;
          RD    <= hold;
        end
      end
    end
  end

  // Memory array: clear sweep or masked store; nothing is written on a reset edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_CLEAR)
        mem[clr_idx] <= '0;
      else if (do_store)
        mem[widx] <= (mem[widx] & ~wmask) | (wdata & wmask);
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: directed scenarios plus random
// traffic, compared against a byte-array reference model.
module tb_data_memory_ctrl;

  localparam int DEPTH    = 16;
  localparam int READ_LAT = 3;
  localparam int BYTES    = DEPTH * 4;

  logic        clk, reset, REQ, WE, UNS;
  logic [1:0]  SIZE;
  logic [31:0] A, WD;
  logic        READY, VALID, FAULT, FAULT_STICKY;
  logic [31:0] RD, FAULT_ADDR;

  data_memory_ctrl #(.DEPTH(DEPTH), .READ_LAT(READ_LAT), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .REQ(REQ), .WE(WE), .SIZE(SIZE), .UNS(UNS),
    .A(A), .WD(WD), .READY(READY), .VALID(VALID), .RD(RD), .FAULT(FAULT),
    .FAULT_ADDR(FAULT_ADDR), .FAULT_STICKY(FAULT_STICKY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: flat byte store plus fault bookkeeping
  logic [7:0]  m [BYTES];
  logic [31:0] m_faddr;
  logic        m_sticky;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_fault(logic [1:0] sz, logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
           || (a >= 32'(BYTES));
  endfunction

  function automatic logic [31:0] model_load(logic [1:0] sz, bit uns, logic [31:0] a);
    int i = int'(a);
    logic [15:0] h;
    if (sz == 2'd0) return uns ? {24'h0, m[i]} : {{24{m[i][7]}}, m[i]};
    h = {m[i+1], m[i]};
    if (sz == 2'd1) return uns ? {16'h0, h} : {{16{h[15]}}, h};
    return {m[i+3], m[i+2], m[i+1], m[i]};
  endfunction

  function automatic void model_store(logic [1:0] sz, logic [31:0] a, logic [31:0] wd);
    int i = int'(a);
    int n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int k = 0; k < n; k++) m[i+k] = 8'(wd >> (8 * k));
  endfunction

  // Reset for one edge, then expect the clear sweep to take exactly DEPTH edges
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_valid", VALID, 0);
    chk("rst_rd", RD, 0);
    chk("rst_fault", FAULT, 0);
    chk("rst_faddr", FAULT_ADDR, 0);
    chk("rst_sticky", FAULT_STICKY, 0);
    chk("rst_ready", READY, 0);
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      if (k < DEPTH) begin
        if (READY !== 1'b0 || VALID !== 1'b0) chk("clr_busy", {READY, VALID}, 0);
      end else begin
        chk("clr_ready", READY, 1);
      end
    end
    for (int i = 0; i < BYTES; i++) m[i] = 8'h0;
    m_faddr  = '0;
    m_sticky = 1'b0;
  endtask

  // One request: wait for READY, accept, then check timing and result
  task automatic xact(input bit we, input logic [1:0] sz, input bit uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd_o);
    int n = 0;
    bit f;
    int lat;
    logic [31:0] erd;
    while (READY !== 1'b1 && n < 50) begin tick(); n++; end
    chk("ready_wait", READY, 1);
    REQ = 1'b1; WE = we; SIZE = sz; UNS = uns; A = a; WD = wd;
    f   = model_fault(sz, a);
    erd = (f || we) ? 32'h0 : model_load(sz, uns, a);
    lat = (f || we) ? 1 : READ_LAT;
    tick();
    REQ = 1'b0;
    if (f) begin m_faddr = a; m_sticky = 1'b1; end
    else if (we) model_store(sz, a, wd);
    for (int k = 1; k <= lat; k++) begin
      if (k < lat) chk("early_valid", VALID, 0);
      else begin
        chk("valid", VALID, 1);
        chk("fault", FAULT, f);
        chk("rd", RD, erd);
      end
      if (!we && !f) chk("busy", READY, 0);
      if (k < lat) tick();
    end
    rd_o = RD;
    chk("faddr", FAULT_ADDR, m_faddr);
    chk("sticky", FAULT_STICKY, m_sticky);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    logic [1:0]  sz;
    reset = 1'b1; REQ = 1'b0; WE = 1'b0; SIZE = 2'd0; UNS = 1'b0; A = '0; WD = '0;
    tick();
    do_reset();

    // Reset clears prior contents
    xact(1, 2'd2, 0, 32'h14, 32'hDEADBEEF, r);
    xact(0, 2'd2, 0, 32'h14, 0, r);
    chk("preload", r, 32'hDEADBEEF);
    do_reset();
    xact(0, 2'd2, 0, 32'h14, 0, r);
    chk("cleared", r, 32'h0);

    // Byte lanes
    xact(1, 2'd2, 0, 32'h8, 32'h11223344, r);
    xact(1, 2'd0, 0, 32'hA, 32'h555555AA, r);
    xact(0, 2'd2, 0, 32'h8, 0, r); chk("lw_lane", r, 32'h11AA3344);
    xact(0, 2'd0, 0, 32'hA, 0, r); chk("lb", r, 32'hFFFFFFAA);
    xact(0, 2'd0, 1, 32'hA, 0, r); chk("lbu", r, 32'h000000AA);

    // Halfwords
    xact(1, 2'd1, 0, 32'h12, 32'h00008001, r);
    xact(0, 2'd1, 0, 32'h12, 0, r); chk("lh", r, 32'hFFFF8001);
    xact(0, 2'd1, 1, 32'h12, 0, r); chk("lhu", r, 32'h00008001);
    xact(1, 2'd2, 0, 32'h10, 32'h12345678, r);
    xact(0, 2'd1, 0, 32'h10, 0, r); chk("lh_lo", r, 32'h00005678);

    // Faults
    xact(1, 2'd2, 0, 32'h4, 32'hCAFEF00D, r);
    xact(1, 2'd2, 0, 32'h6, 32'hFFFFFFFF, r);
    chk("faddr6", FAULT_ADDR, 32'h6);
    xact(0, 2'd2, 0, 32'h4, 0, r); chk("unchanged", r, 32'hCAFEF00D);
    xact(0, 2'd2, 0, 32'(BYTES), 0, r);
    chk("faddr_oor", FAULT_ADDR, 32'(BYTES));
    xact(0, 2'd3, 0, 32'h0, 0, r);
    xact(1, 2'd2, 0, 32'h0, 32'h1, r);
    chk("sticky_hold", FAULT_STICKY, 1);

    // Handshake: second request held while the load is in flight
    while (READY !== 1'b1) tick();
    REQ = 1'b1; WE = 1'b0; SIZE = 2'd2; A = 32'h10;
    tick();
    WE = 1'b1; A = 32'h20; WD = 32'hA5A5_0F0F;
    for (int k = 1; k <= READ_LAT; k++) begin
      chk("hs_busy", READY, 0);
      chk("hs_valid", VALID, (k == READ_LAT));
      if (k == READ_LAT) chk("hs_rd", RD, 32'h12345678);
      tick();
    end
    chk("hs_ready", READY, 1);
    chk("hs_novalid", VALID, 0);
    tick();
    REQ = 1'b0;
    model_store(2'd2, 32'h20, 32'hA5A5_0F0F);
    chk("hs_store_valid", VALID, 1);
    chk("hs_store_fault", FAULT, 0);
    xact(0, 2'd2, 0, 32'h20, 0, r); chk("hs_store_data", r, 32'hA5A50F0F);

    // Reset in the middle of a read
    xact(1, 2'd2, 0, 32'h30, 32'h77778888, r);
    while (READY !== 1'b1) tick();
    REQ = 1'b1; WE = 1'b0; SIZE = 2'd2; A = 32'h30;
    tick();
    REQ = 1'b0;
    chk("mid_busy", READY, 0);
    do_reset();
    xact(0, 2'd2, 0, 32'h30, 0, r); chk("mid_cleared", r, 32'h0);

    // Random traffic
    for (int t = 0; t < 80; t++) begin
      sz = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) sz = 2'd3;
      a = 32'($urandom_range(0, BYTES - 1));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 9) == 0) a = a + 32'(BYTES) * 32'($urandom_range(1, 1000));
      xact(bit'($urandom_range(0, 1)), sz, bit'($urandom_range(0, 1)), a, $urandom, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
